// File: rtl/serout_shifter_pkg.sv
// Shared constants for the SEROUT transmit path: state encoding and frame defaults.
package serout_shifter_pkg;

   // Transmit state encoding (legacy-compatible constants)
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Frame shape defaults
   localparam int unsigned DEFAULT_DATA_BITS = 8;
   localparam int unsigned DEFAULT_STOP_BITS = 1;

   // CPU data bus width
   localparam int unsigned DIN_W = 8;

endpackage

// File: rtl/serout_hold_reg.sv
// SEROUT holding register: CPU writes land here until the shifter consumes them.
module serout_hold_reg
   import serout_shifter_pkg::*;
#(
   parameter int unsigned W = DEFAULT_DATA_BITS
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         wrEn,
   input  logic         load,
   input  logic [W-1:0] wrData,
   output logic [W-1:0] holdData,
   output logic         holdValid,
   output logic         holdValidNext_c
);

   // A write always wins over a simultaneous consume: the old byte goes to the
   // shifter, the new byte stays held and valid.
   always_comb begin
      holdValidNext_c = wrEn | (holdValid & ~load);
   end

   // Holding register and valid flag; a write over a valid byte simply replaces it
   always_ff @(negedge clk or negedge resetn) begin
      if (!resetn) begin
         holdData  <= '0;
         holdValid <= 1'b0;
      end else begin
         if (wrEn) begin
            holdData <= wrData;
         end
         holdValid <= holdValidNext_c;
      end
   end

endmodule

// File: rtl/serout_shifter.sv
// SEROUT transmit path: frames the held byte as start, data LSB-first, stop bit(s),
// one bit per timer bit tick, and raises the SEROR/SEROC interrupt sources.
module serout_shifter
   import serout_shifter_pkg::*;
#(
   parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS,
   parameter int unsigned STOP_BITS = DEFAULT_STOP_BITS
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enn,
   input  logic             addrSerout,
   input  logic [DIN_W-1:0] Din,
   input  logic             bitTick,
   input  logic             forceBreak,
   output logic             serOut,
   output logic             dataNeeded,
   output logic             txDone,
   output logic             txBusy
);

   // One counter serves both data bits and stop bits; DATA_BITS >= STOP_BITS always
   localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   logic [1:0]           state;
   logic [1:0]           nextState;
   logic [DATA_BITS-1:0] shiftReg;
   logic [DATA_BITS-1:0] nextShift;
   logic [CNT_W-1:0]     bitCnt;
   logic [CNT_W-1:0]     nextCnt;
   logic                 lineBit;
   logic                 nextLine;
   logic                 load;
   logic                 tickEn;
   logic                 wrEn;
   logic [DATA_BITS-1:0] holdData;
   logic                 holdValid;
   logic                 holdValidNext_c;

   assign tickEn = enn & bitTick;
   assign wrEn   = enn & addrSerout;

   serout_hold_reg #(
      .W (DATA_BITS)
   ) u_hold (
      .clk             (clk),
      .resetn          (resetn),
      .wrEn            (wrEn),
      .load            (load),
      .wrData          (DATA_BITS'(Din)),
      .holdData        (holdData),
      .holdValid       (holdValid),
      .holdValidNext_c (holdValidNext_c)
   );

   // Next-state, shifter and line-bit decode; a start bit is driven on the same
   // tick that leaves IDLE (or finishes the last stop bit) so every bit is one tick long
   always_comb begin
      nextState = state;
      nextShift = shiftReg;
      nextCnt   = bitCnt;
      nextLine  = lineBit;
      load      = 1'b0;

      case (state)
         ST_IDLE: begin
            nextLine = 1'b1;
            if (tickEn && holdValid) begin
               load      = 1'b1;
               nextShift = holdData;
               nextCnt   = '0;
               nextLine  = 1'b0;
               nextState = ST_START;
            end
         end
         ST_START: begin
            if (tickEn) begin
               nextLine  = shiftReg[0];
               nextCnt   = '0;
               nextState = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tickEn) begin
               if (bitCnt == CNT_W'(DATA_BITS - 1)) begin
                  nextLine  = 1'b1;
                  nextCnt   = '0;
                  nextState = ST_STOP;
               end else begin
                  nextShift = shiftReg >> 1;
                  nextLine  = shiftReg[1];
                  nextCnt   = bitCnt + CNT_W'(1);
               end
            end
         end
         ST_STOP: begin
            if (tickEn) begin
               if (bitCnt == CNT_W'(STOP_BITS - 1)) begin
                  nextCnt = '0;
                  if (holdValid) begin
                     load      = 1'b1;
                     nextShift = holdData;
                     nextLine  = 1'b0;
                     nextState = ST_START;
                  end else begin
                     nextLine  = 1'b1;
                     nextState = ST_IDLE;
                  end
               end else begin
                  nextCnt = bitCnt + CNT_W'(1);
               end
            end
         end
         default: begin
            nextLine  = 1'b1;
            nextCnt   = '0;
            nextState = ST_IDLE;
         end
      endcase
   end

   // State, shifter and registered status; everything holds while enn is low
   always_ff @(negedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         shiftReg   <= '0;
         bitCnt     <= '0;
         lineBit    <= 1'b1;
         dataNeeded <= 1'b0;
         txDone     <= 1'b1;
         txBusy     <= 1'b0;
      end else if (enn) begin
         state      <= nextState;
         shiftReg   <= nextShift;
         bitCnt     <= nextCnt;
         lineBit    <= nextLine;
         dataNeeded <= load;
         txDone     <= (nextState == ST_IDLE) & ~holdValidNext_c;
         txBusy     <= (nextState != ST_IDLE);
      end
   end

   // Break forces the line low without stopping the shifter underneath
   assign serOut = lineBit & ~forceBreak;

endmodule

// File: tb/tb_serout_shifter.sv
// Bench for serout_shifter: directed scenarios plus randomized traffic against a
// frame-level model (queue of pending line bits plus a one-byte holding slot).
module tb_serout_shifter;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;

   logic       clk;
   logic       resetn;
   logic       enn;
   logic       addrSerout;
   logic [7:0] Din;
   logic       bitTick;
   logic       forceBreak;
   logic       serOut;
   logic       dataNeeded;
   logic       txDone;
   logic       txBusy;

   int vectors;
   int miscompares;

   // Reference model state
   logic       mq[$];
   logic       mLine;
   logic       mHoldValid;
   logic [7:0] mHold;
   logic       mBusy;
   logic       mDn;
   logic       mBrk;

   serout_shifter #(
      .DATA_BITS (DATA_BITS),
      .STOP_BITS (STOP_BITS)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .enn        (enn),
      .addrSerout (addrSerout),
      .Din        (Din),
      .bitTick    (bitTick),
      .forceBreak (forceBreak),
      .serOut     (serOut),
      .dataNeeded (dataNeeded),
      .txDone     (txDone),
      .txBusy     (txBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic expSer();
      return mLine & ~mBrk;
   endfunction

   function automatic logic expDone();
      return ~mBusy & ~mHoldValid;
   endfunction

   task automatic modelReset();
      mq.delete();
      mLine      = 1'b1;
      mHoldValid = 1'b0;
      mHold      = 8'h00;
      mBusy      = 1'b0;
      mDn        = 1'b0;
   endtask

   // Drive one clock of inputs, let the DUT's falling edge act, then advance the model
   task automatic step(input logic wr, input logic [7:0] d, input logic tick,
                       input logic en, input logic brk);
      logic dnNew;
      addrSerout = wr;
      Din        = d;
      bitTick    = tick;
      enn        = en;
      forceBreak = brk;
      mBrk       = brk;
      @(negedge clk);
      @(posedge clk);
      if (en) begin
         dnNew = 1'b0;
         if (tick) begin
            if (mq.size() > 0) begin
               mLine = mq.pop_front();
            end else if (mHoldValid) begin
               mLine = 1'b0;
               for (int i = 0; i < int'(DATA_BITS); i++) mq.push_back(mHold[i]);
               for (int i = 0; i < int'(STOP_BITS); i++) mq.push_back(1'b1);
               mHoldValid = 1'b0;
               mBusy      = 1'b1;
               dnNew      = 1'b1;
            end else begin
               mLine = 1'b1;
               mBusy = 1'b0;
            end
         end
         if (wr) begin
            mHold      = d;
            mHoldValid = 1'b1;
         end
         mDn = dnNew;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      vectors += 4;
      if (serOut !== 1'b1) begin miscompares++; $display("FAIL reset_serOut: got %b expected 1", serOut); end
      if (txDone !== 1'b1) begin miscompares++; $display("FAIL reset_txDone: got %b expected 1", txDone); end
      if (txBusy !== 1'b0) begin miscompares++; $display("FAIL reset_txBusy: got %b expected 0", txBusy); end
      if (dataNeeded !== 1'b0) begin miscompares++; $display("FAIL reset_dataNeeded: got %b expected 0", dataNeeded); end
      resetn = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
         vectors += 4;
         if (serOut !== 1'b1) begin miscompares++; $display("FAIL idle_serOut tick %0d: got %b expected 1", k, serOut); end
         if (dataNeeded !== 1'b0) begin miscompares++; $display("FAIL idle_dataNeeded tick %0d: got %b expected 0", k, dataNeeded); end
         if (txDone !== 1'b1) begin miscompares++; $display("FAIL idle_txDone tick %0d: got %b expected 1", k, txDone); end
         if (txBusy !== 1'b0) begin miscompares++; $display("FAIL idle_txBusy tick %0d: got %b expected 0", k, txBusy); end
      end
   endtask

   task automatic test_single_frame();
      logic [9:0] pattern;
      step(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
      vectors += 2;
      if (txDone !== 1'b0) begin miscompares++; $display("FAIL a5_txDone_after_write: got %b expected 0", txDone); end
      if (serOut !== 1'b1) begin miscompares++; $display("FAIL a5_serOut_after_write: got %b expected 1", serOut); end
      // 0xA5 framed: start 0, data 1,0,1,0,0,1,0,1, stop 1 (bit k of pattern = tick k+1)
      pattern = 10'b11_0100_1010;
      for (int k = 1; k <= 11; k++) begin
         step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
         vectors += 3;
         if (serOut !== expSer()) begin miscompares++; $display("FAIL a5_serOut tick %0d: got %b expected %b", k, serOut, expSer()); end
         if (k <= 10 && serOut !== pattern[k-1]) begin miscompares++; $display("FAIL a5_pattern tick %0d: got %b expected %b", k, serOut, pattern[k-1]); end
         if (dataNeeded !== (k == 1)) begin miscompares++; $display("FAIL a5_dataNeeded tick %0d: got %b expected %b", k, dataNeeded, (k == 1)); end
         if (txBusy !== mBusy) begin miscompares++; $display("FAIL a5_txBusy tick %0d: got %b expected %b", k, txBusy, mBusy); end
      end
      vectors++;
      if (txDone !== 1'b1) begin miscompares++; $display("FAIL a5_txDone_end: got %b expected 1", txDone); end
   endtask

   task automatic test_back_to_back();
      int dnTicks[$];
      step(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      if (dataNeeded === 1'b1) dnTicks.push_back(1);
      vectors++;
      if (serOut !== 1'b0) begin miscompares++; $display("FAIL b2b_start_bit: got %b expected 0", serOut); end
      step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
      for (int k = 2; k <= 21; k++) begin
         step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
         if (dataNeeded === 1'b1) dnTicks.push_back(k);
         vectors += 2;
         if (serOut !== expSer()) begin miscompares++; $display("FAIL b2b_serOut tick %0d: got %b expected %b", k, serOut, expSer()); end
         if (k <= 20 && txBusy !== 1'b1) begin miscompares++; $display("FAIL b2b_gap tick %0d: got txBusy %b expected 1", k, txBusy); end
      end
      vectors += 2;
      if (dnTicks.size() != 2 || dnTicks[0] != 1 || dnTicks[1] != 11) begin
         miscompares++;
         $display("FAIL b2b_dataNeeded: got %0d pulses (first %0d) expected 2 at ticks 1,11",
                  dnTicks.size(), (dnTicks.size() > 0) ? dnTicks[0] : -1);
      end
      if (txDone !== 1'b1) begin miscompares++; $display("FAIL b2b_txDone_end: got %b expected 1", txDone); end
   endtask

   task automatic test_overwrite();
      int dnCount;
      dnCount = 0;
      step(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 11; k++) begin
         step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
         if (dataNeeded === 1'b1) dnCount++;
         vectors++;
         if (serOut !== expSer()) begin miscompares++; $display("FAIL ovw_serOut tick %0d: got %b expected %b", k, serOut, expSer()); end
      end
      for (int k = 1; k <= 3; k++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      vectors += 2;
      if (dnCount != 1) begin miscompares++; $display("FAIL ovw_dataNeeded_count: got %0d expected 1", dnCount); end
      if (serOut !== 1'b1 || txBusy !== 1'b0) begin miscompares++; $display("FAIL ovw_second_frame: got serOut %b txBusy %b expected 1 0", serOut, txBusy); end
   endtask

   task automatic test_break();
      logic brk;
      step(1'b1, 8'h0F, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 11; k++) begin
         brk = (k >= 3 && k <= 6);
         step(1'b0, 8'h00, 1'b1, 1'b1, brk);
         vectors++;
         if (serOut !== expSer()) begin miscompares++; $display("FAIL brk_serOut tick %0d: got %b expected %b", k, serOut, expSer()); end
         if (brk) begin
            vectors++;
            if (serOut !== 1'b0) begin miscompares++; $display("FAIL brk_forced_low tick %0d: got %b expected 0", k, serOut); end
         end
      end
      vectors += 2;
      if (txDone !== 1'b1) begin miscompares++; $display("FAIL brk_txDone_end: got %b expected 1", txDone); end
      if (txBusy !== 1'b0) begin miscompares++; $display("FAIL brk_txBusy_end: got %b expected 0", txBusy); end
   endtask

   task automatic test_reset_midframe();
      step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      #2 resetn = 1'b0;
      modelReset();
      #1;
      vectors += 3;
      if (serOut !== 1'b1) begin miscompares++; $display("FAIL rst_mid_serOut: got %b expected 1", serOut); end
      if (txDone !== 1'b1) begin miscompares++; $display("FAIL rst_mid_txDone: got %b expected 1", txDone); end
      if (txBusy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_txBusy: got %b expected 0", txBusy); end
      @(posedge clk);
      resetn = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
         vectors += 3;
         if (serOut !== 1'b1) begin miscompares++; $display("FAIL rst_mid_noframe tick %0d: got %b expected 1", k, serOut); end
         if (dataNeeded !== 1'b0) begin miscompares++; $display("FAIL rst_mid_dataNeeded tick %0d: got %b expected 0", k, dataNeeded); end
         if (txDone !== 1'b1) begin miscompares++; $display("FAIL rst_mid_txDone tick %0d: got %b expected 1", k, txDone); end
      end
   endtask

   task automatic test_random();
      logic wr, tick, en, brk;
      logic [7:0] d;
      for (int n = 0; n < 1500; n++) begin
         en   = ($urandom_range(0, 7) != 0);
         tick = ($urandom_range(0, 2) == 0);
         wr   = ($urandom_range(0, mBusy ? 9 : 14) == 0);
         brk  = ($urandom_range(0, 24) == 0);
         d    = 8'($urandom);
         step(wr, d, tick, en, brk);
         vectors += 4;
         if (serOut !== expSer()) begin miscompares++; $display("FAIL rnd_serOut step %0d: got %b expected %b", n, serOut, expSer()); end
         if (dataNeeded !== mDn) begin miscompares++; $display("FAIL rnd_dataNeeded step %0d: got %b expected %b", n, dataNeeded, mDn); end
         if (txDone !== expDone()) begin miscompares++; $display("FAIL rnd_txDone step %0d: got %b expected %b", n, txDone, expDone()); end
         if (txBusy !== mBusy) begin miscompares++; $display("FAIL rnd_txBusy step %0d: got %b expected %b", n, txBusy, mBusy); end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      resetn      = 1'b0;
      enn         = 1'b0;
      addrSerout  = 1'b0;
      Din         = 8'h00;
      bitTick     = 1'b0;
      forceBreak  = 1'b0;
      mBrk        = 1'b0;
      modelReset();
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overwrite();
      test_break();
      test_reset_midframe();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
